efuse_ctrl: RTL and testbench

Controller for the 128x8 one-time-programmable eFuse macro (TEF65GP128x8HD pin set). It accepts single-word read and program requests from the host side over a valid/ready interface and drives the macro's CSB/STROBE/LOAD/PGENB/VDDQ/A pins with configurable setup, pulse and hold cycle counts. Program operations blow only the bits set in the write data, one bit per STROBE pulse. Each program is followed automatically by a verify read.

---
 rtl/efuse_ctrl_if.sv | 22 ++
 rtl/efuse_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_efuse_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/efuse_ctrl_if.sv
// Host-side request/response channel of the eFuse controller.
// The host drives requests through the master modport; the controller answers through the slave modport.
interface efuse_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/efuse_ctrl.sv
// Sequencer for a 128x8 OTP eFuse macro: single-word reads and bit-serial programs,
// each program followed by an automatic verify read. All macro pins are registered.
module efuse_ctrl #(
    parameter int NUM_WORDS = 128,
    parameter int T_SETUP   = 2,
    parameter int T_PGM     = 8,
    parameter int T_RD      = 2,
    parameter int T_HOLD    = 2
) (
    input  logic         clk,
    input  logic         rst,
    efuse_ctrl_if.slave  host,
    output logic         busy,
    output logic         efuse_csb,
    output logic         efuse_strobe,
    output logic         efuse_load,
    output logic         efuse_pgenb,
    output logic         efuse_vddq,
    output logic [9:0]   efuse_a,
    input  logic [7:0]   efuse_q
);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, GAP, DONE} state_t;

    // Mode pin bundle ordering: {csb, load, pgenb, vddq}
    localparam logic [3:0] MODE_IDLE = 4'b1010;
    localparam logic [3:0] MODE_RD   = 4'b0110;
    localparam logic [3:0] MODE_PGM  = 4'b0001;

    localparam logic [15:0] SETUP_LAST = 16'(T_SETUP - 1);
    localparam logic [15:0] PGM_LAST   = 16'(T_PGM - 1);
    localparam logic [15:0] RD_LAST    = 16'(T_RD - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(T_HOLD - 1);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [7:0]  pend_q;
    logic [7:0]  pend_d;
    logic [2:0]  cur_bit;
    logic        pgm_q;
    logic        wr_q;
    logic [6:0]  addr_q;
    logic [7:0]  wdata_q;
    logic        rsp_valid_q;
    logic [7:0]  rsp_rdata_q;
    logic        rsp_err_q;
    logic [3:0]  mode_q;
    logic        strobe_q;
    logic [9:0]  a_q;
    logic        accept;
    logic        in_range;

    function automatic logic [2:0] lowest_bit(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign host.req_ready = (state_q == IDLE) && !rst;
    assign accept         = host.req_valid && host.req_ready;
    assign in_range       = 32'(host.req_addr) < 32'(NUM_WORDS);
    assign busy           = (state_q != IDLE);

    assign cur_bit = lowest_bit(pend_q);
    assign pend_d  = pend_q & ~(8'd1 << cur_bit);

    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_rdata = rsp_rdata_q;
    assign host.rsp_err   = rsp_err_q;

    assign {efuse_csb, efuse_load, efuse_pgenb, efuse_vddq} = mode_q;
    assign efuse_strobe = strobe_q;
    assign efuse_a      = a_q;

    // Request payload needs no reset: it is only consumed after an acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= host.req_addr;
            wdata_q <= host.req_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_q      <= '0;
            pgm_q       <= 1'b0;
            wr_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mode_q      <= MODE_IDLE;
            strobe_q    <= 1'b0;
            a_q         <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        wr_q  <= host.req_write;
                        cnt_q <= '0;
                        if (!in_range) begin
                            state_q     <= DONE;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_rdata_q <= '0;
                        end else if (host.req_write && (|host.req_wdata)) begin
                            state_q <= SETUP;
                            pgm_q   <= 1'b1;
                            pend_q  <= host.req_wdata;
                            mode_q  <= MODE_PGM;
                            a_q     <= {lowest_bit(host.req_wdata), host.req_addr};
                        end else begin
                            state_q <= SETUP;
                            pgm_q   <= 1'b0;
                            mode_q  <= MODE_RD;
                            a_q     <= {3'b000, host.req_addr};
                        end
                    end
                end
                SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        state_q  <= PULSE;
                        strobe_q <= 1'b1;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                PULSE: begin
                    if (cnt_q == (pgm_q ? PGM_LAST : RD_LAST)) begin
                        state_q  <= HOLD;
                        strobe_q <= 1'b0;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_q <= '0;
                        if (pgm_q && (|pend_d)) begin
                            state_q <= SETUP;
                            pend_q  <= pend_d;
                            a_q     <= {lowest_bit(pend_d), addr_q};
                        end else if (pgm_q) begin
                            state_q <= GAP;
                            pend_q  <= '0;
                            pgm_q   <= 1'b0;
                            mode_q  <= MODE_IDLE;
                            a_q     <= '0;
                        end else begin
                            // efuse_q settled on the strobe falling edge; sample it now
                            state_q     <= DONE;
                            mode_q      <= MODE_IDLE;
                            a_q         <= '0;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= efuse_q;
                            rsp_err_q   <= wr_q && ((efuse_q & wdata_q) != wdata_q);
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                GAP: begin
                    state_q <= SETUP;
                    mode_q  <= MODE_RD;
                    a_q     <= {3'b000, addr_q};
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_efuse_ctrl.sv
// Directed bench for efuse_ctrl against a behavioural 10-word eFuse macro model.
module tb_efuse_ctrl;

    logic       clk;
    logic       rst;
    logic       busy;
    logic       efuse_csb, efuse_strobe, efuse_load, efuse_pgenb, efuse_vddq;
    logic [9:0] efuse_a;
    logic [7:0] efuse_q;
    logic [7:0] q_model;
    logic       force_en;

    efuse_ctrl_if bus ();

    efuse_ctrl #(.NUM_WORDS(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .host         (bus.slave),
        .busy         (busy),
        .efuse_csb    (efuse_csb),
        .efuse_strobe (efuse_strobe),
        .efuse_load   (efuse_load),
        .efuse_pgenb  (efuse_pgenb),
        .efuse_vddq   (efuse_vddq),
        .efuse_a      (efuse_a),
        .efuse_q      (efuse_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model: fuses blow on a program strobe, read data updates on the read strobe fall.
    logic [7:0] mem [0:15];
    assign efuse_q = force_en ? 8'h01 : q_model;

    always @(posedge efuse_strobe) begin
        if (!efuse_csb && !efuse_pgenb && efuse_vddq && !efuse_load)
            mem[efuse_a[6:0] & 7'h0f][efuse_a[9:7]] = 1'b1;
    end

    always @(negedge efuse_strobe) begin
        if (!efuse_csb && efuse_load && efuse_pgenb && !efuse_vddq)
            q_model = (efuse_a[6:0] < 7'd10) ? mem[efuse_a[6:0] & 7'h0f] : 8'h00;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Pin monitor, sampled mid-cycle on the falling clock edge.
    int         pgm_pulses = 0;
    int         rd_pulses  = 0;
    int         csb_low    = 0;
    int         rsp_cnt    = 0;
    int         viol       = 0;
    int         len        = 0;
    logic [9:0] pgm_a [8];
    logic [3:0] rd_mode    = 4'h0;
    logic [9:0] rd_a       = 10'h0;
    logic       prev_strobe = 1'b0;
    logic [9:0] prev_a      = 10'h0;
    logic [3:0] prev_mode   = 4'b1010;
    logic [3:0] cur_mode;
    logic       rst_prev    = 1'b1;

    always @(negedge clk) begin
        cur_mode = {efuse_csb, efuse_load, efuse_pgenb, efuse_vddq};
        if (bus.rsp_valid) rsp_cnt++;
        if (!efuse_csb) csb_low++;
        if (!rst && !rst_prev) begin
            if ((efuse_strobe != prev_strobe) && ((efuse_a != prev_a) || (cur_mode != prev_mode)))
                viol++;
            if (efuse_strobe && !prev_strobe) begin
                if (!efuse_pgenb) begin
                    if (pgm_pulses < 8) pgm_a[pgm_pulses] = efuse_a;
                    pgm_pulses++;
                end else begin
                    rd_pulses++;
                    rd_mode = cur_mode;
                    rd_a    = efuse_a;
                end
                len = 0;
            end
            if (efuse_strobe) len++;
            if (!efuse_strobe && prev_strobe && (len != (efuse_pgenb ? 2 : 8))) viol++;
        end
        prev_strobe = efuse_strobe;
        prev_a      = efuse_a;
        prev_mode   = cur_mode;
        rst_prev    = rst;
    end

    task automatic do_req(input logic wr, input logic [6:0] addr, input logic [7:0] wd,
                          output logic [7:0] rd, output logic er, output int n);
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("req_ready", 32'(bus.req_ready), 32'd1);
        pgm_pulses    = 0;
        rd_pulses     = 0;
        csb_low       = 0;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 1;
        while (!bus.rsp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        rd = bus.rsp_rdata;
        er = bus.rsp_err;
    endtask

    logic [7:0] rd;
    logic       er;
    int         n;
    int         rsp0;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        mem[1]        = 8'hFF;
        q_model       = 8'h00;
        force_en      = 1'b0;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 7'd0;
        bus.req_wdata = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("rst_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pins", 32'({efuse_csb, efuse_strobe, efuse_load, efuse_pgenb, efuse_vddq, efuse_a}),
            32'({1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h000}));
        #2 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(bus.req_ready), 32'd1);

        // 1: plain read of a fully blown word
        do_req(1'b0, 7'd1, 8'h00, rd, er, n);
        chk("t1_rdata", 32'(rd), 32'hFF);
        chk("t1_err", 32'(er), 32'd0);
        chk("t1_n", 32'(n), 32'd7);
        chk("t1_mode", 32'(rd_mode), 32'b0110);
        chk("t1_a", 32'(rd_a), 32'h001);

        // 2: program bits 0 and 2 of word 0, then read back-to-back
        do_req(1'b1, 7'd0, 8'h05, rd, er, n);
        chk("t2_rdata", 32'(rd), 32'h05);
        chk("t2_err", 32'(er), 32'd0);
        chk("t2_n", 32'(n), 32'd32);
        chk("t2_pgm_pulses", 32'(pgm_pulses), 32'd2);
        chk("t2_a0", 32'(pgm_a[0]), 32'h000);
        chk("t2_a1", 32'(pgm_a[1]), 32'h100);
        chk("t2_rd_pulses", 32'(rd_pulses), 32'd1);
        do_req(1'b0, 7'd0, 8'h00, rd, er, n);
        chk("t2_readback", 32'(rd), 32'h05);
        chk("t2_readback_n", 32'(n), 32'd7);

        // 3: program with empty data only verifies
        do_req(1'b1, 7'd2, 8'h00, rd, er, n);
        chk("t3_rdata", 32'(rd), 32'h00);
        chk("t3_err", 32'(er), 32'd0);
        chk("t3_n", 32'(n), 32'd7);
        chk("t3_pgm_pulses", 32'(pgm_pulses), 32'd0);
        chk("t3_rd_pulses", 32'(rd_pulses), 32'd1);

        // 4: out-of-range address
        do_req(1'b0, 7'd10, 8'h00, rd, er, n);
        chk("t4_n", 32'(n), 32'd1);
        chk("t4_err", 32'(er), 32'd1);
        chk("t4_rdata", 32'(rd), 32'h00);
        chk("t4_csb_low", 32'(csb_low), 32'd0);

        // 5: reset during the third program strobe cycle
        @(negedge clk);
        while (!bus.req_ready) @(negedge clk);
        rsp0          = rsp_cnt;
        bus.req_write = 1'b1;
        bus.req_addr  = 7'd3;
        bus.req_wdata = 8'h80;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("t5_strobe_pre", 32'(efuse_strobe), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t5_strobe_rst", 32'(efuse_strobe), 32'd0);
        chk("t5_csb_rst", 32'(efuse_csb), 32'd1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_no_rsp", 32'(rsp_cnt), 32'(rsp0));
        chk("t5_busy", 32'(busy), 32'd0);
        do_req(1'b0, 7'd1, 8'h00, rd, er, n);
        chk("t5_read_rdata", 32'(rd), 32'hFF);
        chk("t5_read_n", 32'(n), 32'd7);

        // 6: verify mismatch with forced read data
        force_en = 1'b1;
        do_req(1'b1, 7'd4, 8'h03, rd, er, n);
        force_en = 1'b0;
        chk("t6_err", 32'(er), 32'd1);
        chk("t6_rdata", 32'(rd), 32'h01);
        chk("t6_n", 32'(n), 32'd32);
        chk("t6_pgm_pulses", 32'(pgm_pulses), 32'd2);

        chk("pin_timing_viol", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
